// File: rtl/ag_tcu_uop_sequencer_pkg.sv
// Shared constants and tile-geometry helpers for the AG tensor-core micro-op sequencer.
// Tile/block shapes are derived from the warp lane count so one RTL serves every build.
package ag_tcu_uop_sequencer_pkg;

  localparam int AG_TCU_NR = 8;
  localparam int AG_TCU_DP = 0;
  localparam int AG_TCU_RA = 0;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } ag_tcu_seq_state_e;

  function automatic int ag_tcu_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A dimension with a single step still needs a 1-bit (constant 0) index.
  function automatic int ag_tcu_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ag_tcu_tile_m(input int nt);
    int lg;
    lg = $clog2(nt * AG_TCU_NR);
    return 1 << (lg - lg / 2);
  endfunction

  function automatic int ag_tcu_tile_n(input int nt);
    int lg;
    lg = $clog2(nt * AG_TCU_NR);
    return 1 << (lg / 2);
  endfunction

  function automatic int ag_tcu_tile_k(input int nt);
    return (nt * AG_TCU_NR) / ag_tcu_max(ag_tcu_tile_m(nt), ag_tcu_tile_n(nt));
  endfunction

  function automatic int ag_tcu_tc_m(input int nt);
    int lg;
    lg = $clog2(nt);
    return 1 << (lg - lg / 2);
  endfunction

  function automatic int ag_tcu_tc_n(input int nt);
    int lg;
    lg = $clog2(nt);
    return 1 << (lg / 2);
  endfunction

  function automatic int ag_tcu_tc_k(input int nt);
    return (AG_TCU_DP != 0) ? AG_TCU_DP : nt / ag_tcu_max(ag_tcu_tc_m(nt), ag_tcu_tc_n(nt));
  endfunction

  function automatic int ag_tcu_m_steps(input int nt);
    return ag_tcu_tile_m(nt) / ag_tcu_tc_m(nt);
  endfunction

  function automatic int ag_tcu_n_steps(input int nt);
    return ag_tcu_tile_n(nt) / ag_tcu_tc_n(nt);
  endfunction

  function automatic int ag_tcu_k_steps(input int nt);
    return ag_tcu_tile_k(nt) / ag_tcu_tc_k(nt);
  endfunction

  function automatic int ag_tcu_b_sub_blocks(input int nt);
    return nt / (ag_tcu_tc_k(nt) * ag_tcu_tc_n(nt));
  endfunction

  function automatic int ag_tcu_nrb(input int nt);
    return (ag_tcu_tile_n(nt) * ag_tcu_tile_k(nt)) / nt;
  endfunction

  function automatic int ag_tcu_rb(input int nt);
    return (ag_tcu_nrb(nt) == 4) ? 28 : 10;
  endfunction

  function automatic int ag_tcu_rc(input int nt);
    return (ag_tcu_nrb(nt) == 4) ? 10 : 24;
  endfunction

endpackage

// File: rtl/ag_tcu_uop_sequencer_step_counter.sv
// Nested (m,n,k) block-step counter: k innermost, m outermost, each wrapping at its
// step count. 'last' flags the final step of the whole walk.
module ag_tcu_step_counter
  import ag_tcu_uop_sequencer_pkg::*;
#(
  parameter int M_STEPS = 2,
  parameter int N_STEPS = 4,
  parameter int K_STEPS = 4,
  localparam int SMW = ag_tcu_idx_w(M_STEPS),
  localparam int SNW = ag_tcu_idx_w(N_STEPS),
  localparam int SKW = ag_tcu_idx_w(K_STEPS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           en,
  output logic [SMW-1:0] m_idx,
  output logic [SNW-1:0] n_idx,
  output logic [SKW-1:0] k_idx,
  output logic           last
);

  logic m_max, n_max, k_max;

  assign m_max = (m_idx == SMW'(M_STEPS - 1));
  assign n_max = (n_idx == SNW'(N_STEPS - 1));
  assign k_max = (k_idx == SKW'(K_STEPS - 1));
  assign last  = m_max & n_max & k_max;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      m_idx <= '0;
      n_idx <= '0;
      k_idx <= '0;
    end else if (en) begin
      if (k_max) begin
        k_idx <= '0;
        if (n_max) begin
          n_idx <= '0;
          m_idx <= m_max ? '0 : m_idx + 1'b1;
        end else begin
          n_idx <= n_idx + 1'b1;
        end
      end else begin
        k_idx <= k_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ag_tcu_uop_sequencer.sv
// Expands one WMMA instruction into a stream of TCU micro-ops with block steps and
// A/B/C register indices; carries control and addressing only, never operand data.
//
// state    | meaning
// SEQ_IDLE | no instruction held, in_ready=1, out_valid=0
// SEQ_BUSY | instruction captured, presenting micro-op (m,n,k), out_valid=1
module ag_tcu_uop_sequencer
  import ag_tcu_uop_sequencer_pkg::*;
#(
  parameter int NUM_THREADS = 8,
  parameter int NUM_WARPS   = 4,
  parameter int UUID_WIDTH  = 44,
  parameter int REG_BITS    = 5,
  localparam int NW_BITS = ag_tcu_max(1, $clog2(NUM_WARPS)),
  localparam int M_STEPS = ag_tcu_m_steps(NUM_THREADS),
  localparam int N_STEPS = ag_tcu_n_steps(NUM_THREADS),
  localparam int K_STEPS = ag_tcu_k_steps(NUM_THREADS),
  localparam int UOPS    = M_STEPS * N_STEPS * K_STEPS,
  localparam int SMW     = ag_tcu_idx_w(M_STEPS),
  localparam int SNW     = ag_tcu_idx_w(N_STEPS),
  localparam int SKW     = ag_tcu_idx_w(K_STEPS),
  localparam int UIW     = ag_tcu_idx_w(UOPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NW_BITS-1:0]    in_wid,
  input  logic [UUID_WIDTH-1:0] in_uuid,
  input  logic [3:0]            in_fmt_s,
  input  logic [3:0]            in_fmt_d,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NW_BITS-1:0]    out_wid,
  output logic [UUID_WIDTH-1:0] out_uuid,
  output logic [3:0]            out_fmt_s,
  output logic [3:0]            out_fmt_d,
  output logic [REG_BITS-1:0]   out_rs1,
  output logic [REG_BITS-1:0]   out_rs2,
  output logic [REG_BITS-1:0]   out_rs3,
  output logic [REG_BITS-1:0]   out_rd,
  output logic [SMW-1:0]        out_step_m,
  output logic [SNW-1:0]        out_step_n,
  output logic [SKW-1:0]        out_step_k,
  output logic                  out_first_k,
  output logic                  out_last_k,
  output logic                  out_last,
  output logic [UIW-1:0]        out_uop_idx,
  output logic                  busy
);

  localparam int B_SUB = ag_tcu_b_sub_blocks(NUM_THREADS);
  localparam int RB    = ag_tcu_rb(NUM_THREADS);
  localparam int RC    = ag_tcu_rc(NUM_THREADS);

  typedef struct packed {
    logic [NW_BITS-1:0]    wid;
    logic [UUID_WIDTH-1:0] uuid;
    logic [3:0]            fmt_s;
    logic [3:0]            fmt_d;
  } ag_tcu_instr_t;

  typedef struct packed {
    ag_tcu_instr_t         instr;
    logic [REG_BITS-1:0]   rs1;
    logic [REG_BITS-1:0]   rs2;
    logic [REG_BITS-1:0]   rs3;
    logic [REG_BITS-1:0]   rd;
    logic [SMW-1:0]        step_m;
    logic [SNW-1:0]        step_n;
    logic [SKW-1:0]        step_k;
    logic                  first_k;
    logic                  last_k;
    logic                  last;
    logic [UIW-1:0]        uop_idx;
  } ag_tcu_uop_t;

  ag_tcu_seq_state_e state_q, state_d;
  ag_tcu_instr_t     instr_q;
  ag_tcu_uop_t       uop;

  logic [SMW-1:0] m_idx;
  logic [SNW-1:0] n_idx;
  logic [SKW-1:0] k_idx;
  logic           cnt_last;
  logic           accept, fire, fire_last;
  logic [31:0]    rs1_w, rs2_w, rs3_w, idx_w;

  assign out_valid = (state_q == SEQ_BUSY);
  assign busy      = (state_q == SEQ_BUSY);
  assign fire      = out_valid & out_ready;
  assign fire_last = fire & cnt_last;
  // A new instruction may slip in on the final handshake so back-to-back WMMAs see no bubble.
  assign in_ready  = (state_q == SEQ_IDLE) | fire_last;
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: if (accept) state_d = SEQ_BUSY;
      SEQ_BUSY: if (fire_last && !accept) state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
    end else if (accept) begin
      instr_q <= '{wid: in_wid, uuid: in_uuid, fmt_s: in_fmt_s, fmt_d: in_fmt_d};
    end
  end

  ag_tcu_step_counter #(
    .M_STEPS (M_STEPS),
    .N_STEPS (N_STEPS),
    .K_STEPS (K_STEPS)
  ) u_step_counter (
    .clk   (clk),
    .reset (reset),
    .clear (accept | fire_last),
    .en    (fire),
    .m_idx (m_idx),
    .n_idx (n_idx),
    .k_idx (k_idx),
    .last  (cnt_last)
  );

  assign rs1_w = 32'(AG_TCU_RA) + 32'(m_idx) * 32'(K_STEPS) + 32'(k_idx);
  assign rs2_w = 32'(RB) + (32'(k_idx) * 32'(N_STEPS) + 32'(n_idx)) / 32'(B_SUB);
  assign rs3_w = 32'(RC) + 32'(m_idx) * 32'(N_STEPS) + 32'(n_idx);
  assign idx_w = (32'(m_idx) * 32'(N_STEPS) + 32'(n_idx)) * 32'(K_STEPS) + 32'(k_idx);

  // Data is forced to zero whenever nothing is presented, so idle outputs are clean.
  always_comb begin
    uop = '0;
    if (state_q == SEQ_BUSY) begin
      uop.instr   = instr_q;
      uop.rs1     = REG_BITS'(rs1_w);
      uop.rs2     = REG_BITS'(rs2_w);
      uop.rs3     = REG_BITS'(rs3_w);
      uop.rd      = REG_BITS'(rs3_w);
      uop.step_m  = m_idx;
      uop.step_n  = n_idx;
      uop.step_k  = k_idx;
      uop.first_k = (k_idx == '0);
      uop.last_k  = (k_idx == SKW'(K_STEPS - 1));
      uop.last    = cnt_last;
      uop.uop_idx = UIW'(idx_w);
    end
  end

  assign out_wid     = uop.instr.wid;
  assign out_uuid    = uop.instr.uuid;
  assign out_fmt_s   = uop.instr.fmt_s;
  assign out_fmt_d   = uop.instr.fmt_d;
  assign out_rs1     = uop.rs1;
  assign out_rs2     = uop.rs2;
  assign out_rs3     = uop.rs3;
  assign out_rd      = uop.rd;
  assign out_step_m  = uop.step_m;
  assign out_step_n  = uop.step_n;
  assign out_step_k  = uop.step_k;
  assign out_first_k = uop.first_k;
  assign out_last_k  = uop.last_k;
  assign out_last    = uop.last;
  assign out_uop_idx = uop.uop_idx;

endmodule

// File: tb/tb_ag_tcu_uop_sequencer.sv
// Randomized bench for the TCU micro-op sequencer: an 8-lane and a 4-lane build share
// stimulus, and the selected one is compared against a queue-based micro-op model.
module tb_ag_tcu_uop_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready;
  logic [1:0]  in_wid;
  logic [43:0] in_uuid;
  logic [3:0]  in_fmt_s, in_fmt_d;

  logic        in_ready_a, out_valid_a, first_k_a, last_k_a, last_a, busy_a;
  logic [1:0]  wid_a;
  logic [43:0] uuid_a;
  logic [3:0]  fs_a, fd_a;
  logic [4:0]  rs1_a, rs2_a, rs3_a, rd_a;
  logic [0:0]  sm_a;
  logic [1:0]  sn_a, sk_a;
  logic [4:0]  idx_a;

  logic        in_ready_b, out_valid_b, first_k_b, last_k_b, last_b, busy_b;
  logic [1:0]  wid_b;
  logic [43:0] uuid_b;
  logic [3:0]  fs_b, fd_b;
  logic [4:0]  rs1_b, rs2_b, rs3_b, rd_b;
  logic [1:0]  sm_b;
  logic [0:0]  sn_b, sk_b;
  logic [3:0]  idx_b;

  ag_tcu_uop_sequencer #(.NUM_THREADS(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_wid(in_wid), .in_uuid(in_uuid), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_wid(wid_a), .out_uuid(uuid_a),
    .out_fmt_s(fs_a), .out_fmt_d(fd_a), .out_rs1(rs1_a), .out_rs2(rs2_a), .out_rs3(rs3_a),
    .out_rd(rd_a), .out_step_m(sm_a), .out_step_n(sn_a), .out_step_k(sk_a),
    .out_first_k(first_k_a), .out_last_k(last_k_a), .out_last(last_a),
    .out_uop_idx(idx_a), .busy(busy_a)
  );

  ag_tcu_uop_sequencer #(.NUM_THREADS(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_wid(in_wid), .in_uuid(in_uuid), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_wid(wid_b), .out_uuid(uuid_b),
    .out_fmt_s(fs_b), .out_fmt_d(fd_b), .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rs3(rs3_b),
    .out_rd(rd_b), .out_step_m(sm_b), .out_step_n(sn_b), .out_step_k(sk_b),
    .out_first_k(first_k_b), .out_last_k(last_k_b), .out_last(last_b),
    .out_uop_idx(idx_b), .busy(busy_b)
  );

  // Build geometry: index 0 is the 8-lane build, index 1 the 4-lane build.
  int cfg_m  [2] = '{2, 4};
  int cfg_n  [2] = '{4, 2};
  int cfg_k  [2] = '{4, 2};
  int cfg_bs [2] = '{2, 1};
  int cfg_rb [2] = '{10, 28};
  int cfg_rc [2] = '{24, 10};

  // Known register values for selected micro-ops of each build.
  int plan_sel  [6] = '{0, 0, 0, 0, 1, 1};
  int plan_idx  [6] = '{0, 3, 4, 31, 0, 15};
  int plan_rs1  [6] = '{0, 3, 0, 7, 0, 7};
  int plan_rs2  [6] = '{10, 16, 10, 17, 28, 31};
  int plan_rd   [6] = '{24, 24, 25, 31, 10, 17};
  int plan_last [6] = '{0, 0, 0, 1, 0, 1};

  typedef struct {
    int          idx, m, n, k, rs1, rs2, rd;
    bit          first_k, last_k, last;
    logic [1:0]  wid;
    logic [43:0] uuid;
    logic [3:0]  fs, fd;
  } exp_uop_t;

  exp_uop_t q[$];
  int  sel;
  int  n_vec, n_err, n_fire, n_acc;
  bit  pend, zero_chk, plan_chk;

  logic        o_valid, o_ready, o_busy, o_fk, o_lk, o_last, o_any;
  logic [1:0]  o_wid;
  logic [43:0] o_uuid;
  logic [3:0]  o_fs, o_fd;
  logic [4:0]  o_rs1, o_rs2, o_rs3, o_rd, o_idx;
  logic [1:0]  o_m, o_n, o_k;

  always_comb begin
    if (sel == 0) begin
      o_valid = out_valid_a; o_ready = in_ready_a; o_busy = busy_a;
      o_fk = first_k_a; o_lk = last_k_a; o_last = last_a;
      o_wid = wid_a; o_uuid = uuid_a; o_fs = fs_a; o_fd = fd_a;
      o_rs1 = rs1_a; o_rs2 = rs2_a; o_rs3 = rs3_a; o_rd = rd_a; o_idx = idx_a;
      o_m = 2'(sm_a); o_n = sn_a; o_k = sk_a;
    end else begin
      o_valid = out_valid_b; o_ready = in_ready_b; o_busy = busy_b;
      o_fk = first_k_b; o_lk = last_k_b; o_last = last_b;
      o_wid = wid_b; o_uuid = uuid_b; o_fs = fs_b; o_fd = fd_b;
      o_rs1 = rs1_b; o_rs2 = rs2_b; o_rs3 = rs3_b; o_rd = rd_b; o_idx = 5'(idx_b);
      o_m = sm_b; o_n = 2'(sn_b); o_k = 2'(sk_b);
    end
    o_any = |{o_fk, o_lk, o_last, o_wid, o_uuid, o_fs, o_fd, o_rs1, o_rs2, o_rs3,
              o_rd, o_idx, o_m, o_n, o_k};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic push_instr(input logic [1:0] wid, input logic [43:0] uuid,
                            input logic [3:0] fs, input logic [3:0] fd);
    int mm, nn, kk, tot;
    mm = cfg_m[sel]; nn = cfg_n[sel]; kk = cfg_k[sel];
    tot = mm * nn * kk;
    for (int i = 0; i < tot; i++) begin
      exp_uop_t u;
      u.idx = i;
      u.k = i % kk;
      u.n = (i / kk) % nn;
      u.m = i / (kk * nn);
      u.rs1 = u.m * kk + u.k;
      u.rs2 = cfg_rb[sel] + (u.k * nn + u.n) / cfg_bs[sel];
      u.rd = cfg_rc[sel] + u.m * nn + u.n;
      u.first_k = (u.k == 0);
      u.last_k = (u.k == kk - 1);
      u.last = (i == tot - 1);
      u.wid = wid; u.uuid = uuid; u.fs = fs; u.fd = fd;
      q.push_back(u);
    end
  endtask

  // One clock: optionally offer a new instruction, drive out_ready, check, advance model.
  task automatic cycle(input bit offer, input bit rdy);
    bit ev, eir, fire, acc;
    logic [63:0] rnd;
    exp_uop_t h;
    if (!pend && offer) begin
      rnd = {$urandom, $urandom};
      in_uuid = rnd[43:0];
      in_wid = 2'($urandom_range(0, 3));
      in_fmt_s = 4'($urandom_range(0, 15));
      in_fmt_d = 4'($urandom_range(0, 15));
      pend = 1;
    end
    in_valid = pend;
    out_ready = rdy;
    #1;
    ev = (q.size() != 0);
    eir = !ev;
    if (ev) eir = rdy && q[0].last;
    check("out_valid", 64'(o_valid), 64'(ev));
    check("busy", 64'(o_busy), 64'(ev));
    check("in_ready", 64'(o_ready), 64'(eir));
    if (ev) begin
      h = q[0];
      check("uop_idx", 64'(o_idx), 64'(h.idx));
      check("step_m", 64'(o_m), 64'(h.m));
      check("step_n", 64'(o_n), 64'(h.n));
      check("step_k", 64'(o_k), 64'(h.k));
      check("rs1", 64'(o_rs1), 64'(h.rs1));
      check("rs2", 64'(o_rs2), 64'(h.rs2));
      check("rs3", 64'(o_rs3), 64'(h.rd));
      check("rd", 64'(o_rd), 64'(h.rd));
      check("first_k", 64'(o_fk), 64'(h.first_k));
      check("last_k", 64'(o_lk), 64'(h.last_k));
      check("last", 64'(o_last), 64'(h.last));
      check("wid", 64'(o_wid), 64'(h.wid));
      check("uuid", 64'(o_uuid), 64'(h.uuid));
      check("fmt_s", 64'(o_fs), 64'(h.fs));
      check("fmt_d", 64'(o_fd), 64'(h.fd));
      if (plan_chk) begin
        for (int p = 0; p < 6; p++) begin
          if (plan_sel[p] == sel && plan_idx[p] == h.idx) begin
            check("plan_rs1", 64'(o_rs1), 64'(plan_rs1[p]));
            check("plan_rs2", 64'(o_rs2), 64'(plan_rs2[p]));
            check("plan_rd", 64'(o_rd), 64'(plan_rd[p]));
            check("plan_last", 64'(o_last), 64'(plan_last[p]));
          end
        end
      end
    end else if (zero_chk) begin
      check("idle_data_zero", 64'(o_any), 64'(0));
    end
    zero_chk = 0;
    fire = ev && rdy;
    acc = pend && eir;
    if (fire) begin
      void'(q.pop_front());
      n_fire++;
    end
    if (acc) begin
      push_instr(in_wid, in_uuid, in_fmt_s, in_fmt_d);
      pend = 0;
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    out_ready = 0;
    pend = 0;
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    zero_chk = 1;
  endtask

  bit patt [4] = '{1, 0, 0, 1};
  bit reached;

  initial begin
    n_vec = 0; n_err = 0; n_fire = 0; n_acc = 0;
    pend = 0; zero_chk = 0; plan_chk = 1; sel = 0;
    reset = 1; in_valid = 0; out_ready = 0;
    in_wid = '0; in_uuid = '0; in_fmt_s = '0; in_fmt_d = '0;
    @(posedge clk);
    do_reset();

    // Single instruction, always ready; idle afterwards.
    for (int c = 0; c < 40; c++) cycle(c == 0, 1'b1);

    // Back-to-back: second instruction held until the last handshake of the first.
    n_fire = 0; n_acc = 0;
    for (int c = 0; c < 65; c++) cycle(n_acc < 2, 1'b1);
    check("b2b_fires", 64'(n_fire), 64'(64));
    check("b2b_accepts", 64'(n_acc), 64'(2));
    cycle(1'b0, 1'b1);

    // Backpressure pattern 1,0,0,1.
    n_fire = 0;
    for (int c = 0; c < 80; c++) cycle(c == 0, patt[c % 4]);
    check("bp_fires", 64'(n_fire), 64'(32));

    // Reset while presenting uop 10.
    reached = 0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (q.size() != 0 && q[0].idx == 10) reached = 1;
      else cycle(c == 0, 1'b1);
    end
    check("reach_uop10", 64'(reached), 64'(1));
    do_reset();
    for (int c = 0; c < 40; c++) cycle(c == 0, 1'b1);

    // Random traffic on the 8-lane build.
    for (int c = 0; c < 1500; c++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);

    // 4-lane build.
    sel = 1;
    do_reset();
    for (int c = 0; c < 20; c++) cycle(c == 0, 1'b1);
    for (int c = 0; c < 600; c++)
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ag_tcu_uop_sequencer.md
Name: ag_tcu_uop_sequencer

Overview:
Sits directly upstream of the AG tensor-core datapath. It accepts one WMMA instruction per handshake and expands it into AG_TCU_UOPS micro-ops, each tagged with its (m,n,k) block step and its A/B/C register indices. It issues them in order over a registered valid/ready stream into the TCU execute stage. It holds no operand data, only control and register addressing.

Parameters:
NUM_THREADS, 8, lanes per warp (AG_TCU_NT); all tile/step constants derive from it as in the AG TCU package
NUM_WARPS, 4, warps per core; NW_BITS = max(1, clog2(NUM_WARPS))
UUID_WIDTH, 44, instruction trace id width
REG_BITS, 5, architectural register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  WMMA instruction valid
in_ready  out  1  sequencer can accept an instruction
in_wid  in  NW_BITS  warp id
in_uuid  in  UUID_WIDTH  trace id
in_fmt_s  in  4  source format id (FP16/BF16/I8/U8/I4/U4/FP32)
in_fmt_d  in  4  destination format id (FP32/I32)
out_valid  out  1  micro-op valid
out_ready  in  1  downstream accepts micro-op
out_wid, out_uuid, out_fmt_s, out_fmt_d  out  as input  copied from the captured instruction
out_rs1  out  REG_BITS  A register
out_rs2  out  REG_BITS  B register
out_rs3  out  REG_BITS  C (accumulator) source register
out_rd  out  REG_BITS  destination register (== out_rs3)
out_step_m, out_step_n, out_step_k  out  clog2(max(2,steps)) each  block indices
out_first_k  out  1  k==0: accumulate onto C from out_rs3
out_last_k  out  1  k==K_STEPS-1: result is final for this C block
out_last  out  1  final micro-op of the instruction
out_uop_idx  out  clog2(AG_TCU_UOPS)  linear micro-op index
busy  out  1  instruction in flight

Behaviour:
- Reset: state IDLE; counters 0; out_valid=0; busy=0; all out_* data 0. in_ready=1 in the first cycle after reset deasserts.
- FSM IDLE -> BUSY on in_valid&in_ready. The instruction fields are captured, m=n=k=0, and out_valid=1 on the next cycle (1-cycle latency).
- In BUSY, each out_valid&out_ready advances the counters: k inner, then n, then m outer. Each count wraps to 0 at its step count and carries into the next.
- The uop carrying out_last=1 (m,n,k all at max) returns the FSM to IDLE when accepted, unless a new instruction is accepted in the same cycle. In that case it stays BUSY, restarts at uop 0, and presents it on the next cycle with no bubble.
- in_ready = IDLE | (out_valid & out_ready & out_last).
- Register formulas:
  - rs1 = RA + m*K_STEPS + k
  - rs2 = RB + (k*N_STEPS + n) / B_SUB_BLOCKS
  - rs3 = rd = RC + m*N_STEPS + n
  - RA=0; RB=28 if NRB==4 else 10; RC=10 if NRB==4 else 24
- out_uop_idx = (m*N_STEPS + n)*K_STEPS + k.
- Stall: while out_valid & !out_ready, every out_* holds stable. The counters do not advance.
- busy = (state==BUSY).
- Reset asserted mid-instruction discards it at once. The next cycle shows out_valid=0 and IDLE, with no partial flush.
- in_valid in BUSY without a last-uop handshake is not accepted; the upstream holds it.
- A step count of 1 yields a constant-0 index for that dimension.

Decomposition:
- Add ag_tcu_uop_t (wid, uuid, fmts, rs1/rs2/rs3/rd, steps, first_k, last_k, last, uop_idx) to the AG TCU package.
- Add AG_TCU_RA/RB/RC-derived width constants and the step-index widths to the same package.
- One natural sub-module: ag_tcu_step_counter, a 3-level nested wrap counter with enable, clear, and a terminal flag.

Test Plan:
NUM_THREADS=8 (M/N/K_STEPS=2/4/4, 32 uops, B_SUB_BLOCKS=2), out_ready=1:
- Uop 0 -> rs1=0, rs2=10, rd=24, first_k=1.
- Uop 3 (m0 n0 k3) -> rs1=3, rs2=16, rd=24, last_k=1.
- Uop 4 (m0 n1 k0) -> rs1=0, rs2=10, rd=25, first_k=1.
- Uop 31 -> rs1=7, rs2=17, rd=31, out_last=1; busy drops the next cycle.
- Back-to-back: second in_valid held high -> accepted on the uop-31 handshake; 64 uops over 64 consecutive cycles, uuid switches at uop 32.
- Backpressure: out_ready toggles 1,0,0,1 -> outputs frozen during stalls; uop sequence unchanged; total 32 accepted.
- Reset asserted at uop 10 -> next cycle out_valid=0, in_ready=1. A new instruction then starts at uop 0 with rs1=0.
- NUM_THREADS=4 build (16 uops) -> uop 0: rs2=28, rd=10; uop 15: rs1=7, rs2=31, rd=17, out_last=1.
